// File: rtl/tile_stream_loader.sv
// Byte-stream front end for the NxN inference engine: loads A, B and bias tiles,
// runs the engine start/done handshake and streams the captured int8 result back out.
module tile_stream_loader #(
    parameter int unsigned N          = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic                           eng_start,
    input  logic                           eng_done,
    output logic [N*N*DATA_WIDTH-1:0]      eng_a_data,
    output logic [N*N*DATA_WIDTH-1:0]      eng_b_data,
    output logic [N*ACC_WIDTH-1:0]         eng_bias_data,
    input  logic [N*N*DATA_WIDTH-1:0]      eng_result_quant,
    output logic                           busy,
    output logic [15:0]                    tile_count
);

    localparam int unsigned NumElem  = N * N;
    localparam int unsigned NumBias  = N * ACC_WIDTH / DATA_WIDTH;
    localparam int unsigned ElemIdxW = $clog2(NumElem);
    localparam int unsigned BiasIdxW = $clog2(NumBias);
    localparam int unsigned IdxW     = (ElemIdxW > BiasIdxW) ? ElemIdxW : BiasIdxW;
    localparam logic [IdxW-1:0] LastElem = IdxW'(NumElem - 1);
    localparam logic [IdxW-1:0] LastBias = IdxW'(NumBias - 1);

    typedef enum logic [2:0] {
        StLoadA,
        StLoadB,
        StLoadBias,
        StStart,
        StWait,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [15:0]       tile_cnt_q, tile_cnt_d;

    // Packed 2-D storage: element k sits at [k*DATA_WIDTH +: DATA_WIDTH] of the flat bus.
    // Bias bytes are stored linearly, which gives little-endian words for free.
    logic [NumElem-1:0][DATA_WIDTH-1:0] a_q, b_q, res_q;
    logic [NumBias-1:0][DATA_WIDTH-1:0] bias_q;

    logic a_we, b_we, bias_we, res_we;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tile_cnt_d = tile_cnt_q;
        in_ready   = 1'b0;
        eng_start  = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        a_we       = 1'b0;
        b_we       = 1'b0;
        bias_we    = 1'b0;
        res_we     = 1'b0;

        case (state_q)
            StLoadA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_we = 1'b1;
                    if (idx_q == LastElem) begin
                        idx_d   = '0;
                        state_d = StLoadB;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StLoadB: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    b_we = 1'b1;
                    if (idx_q == LastElem) begin
                        idx_d   = '0;
                        state_d = StLoadBias;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StLoadBias: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    bias_we = 1'b1;
                    if (idx_q == LastBias) begin
                        idx_d   = '0;
                        state_d = StStart;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StStart: begin
                eng_start = 1'b1;
                state_d   = StWait;
            end
            StWait: begin
                if (eng_done) begin
                    res_we  = 1'b1;
                    idx_d   = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                out_valid = 1'b1;
                out_last  = (idx_q == LastElem);
                if (out_ready) begin
                    if (out_last) begin
                        tile_cnt_d = tile_cnt_q + 16'd1;
                        idx_d      = '0;
                        state_d    = StLoadA;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = StLoadA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoadA;
            idx_q      <= '0;
            tile_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tile_cnt_q <= tile_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            bias_q <= '0;
            res_q  <= '0;
        end else begin
            if (a_we) begin
                a_q[idx_q[ElemIdxW-1:0]] <= in_data;
            end
            if (b_we) begin
                b_q[idx_q[ElemIdxW-1:0]] <= in_data;
            end
            if (bias_we) begin
                bias_q[idx_q[BiasIdxW-1:0]] <= in_data;
            end
            if (res_we) begin
                res_q <= eng_result_quant;
            end
        end
    end

    // Result buffer is private so the engine may change its bus while we drain.
    assign out_data      = (state_q == StDrain) ? res_q[idx_q[ElemIdxW-1:0]] : '0;
    assign eng_a_data    = a_q;
    assign eng_b_data    = b_q;
    assign eng_bias_data = bias_q;
    assign busy          = (state_q != StLoadA);
    assign tile_count    = tile_cnt_q;

endmodule

// File: tb/tb_tile_stream_loader.sv
// Directed self-checking bench for tile_stream_loader with a fixed-latency engine model.
module tb_tile_stream_loader;

    localparam int EngLat = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready;
    logic [7:0]   in_data;
    logic         out_valid, out_ready, out_last;
    logic [7:0]   out_data;
    logic         eng_start, eng_done;
    logic [127:0] eng_a_data, eng_b_data, eng_bias_data, eng_result_quant;
    logic         busy;
    logic [15:0]  tile_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tile_stream_loader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .eng_start        (eng_start),
        .eng_done         (eng_done),
        .eng_a_data       (eng_a_data),
        .eng_b_data       (eng_b_data),
        .eng_bias_data    (eng_bias_data),
        .eng_result_quant (eng_result_quant),
        .busy             (busy),
        .tile_count       (tile_count)
    );

    // Reference 4x4 int8 matmul + int32 column bias, saturated to int8.
    function automatic logic [127:0] engine_fn(input logic [127:0] a, input logic [127:0] b,
                                               input logic [127:0] bias);
        logic [127:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = int'($signed(bias[j*32 +: 32]));
                for (int k = 0; k < 4; k++) begin
                    s = s + int'($signed(a[(i*4+k)*8 +: 8])) * int'($signed(b[(k*4+j)*8 +: 8]));
                end
                if (s > 127) s = 127;
                if (s < -128) s = -128;
                r[(i*4+j)*8 +: 8] = 8'(s);
            end
        end
        return r;
    endfunction

    int           eng_cnt;
    logic         eng_done_m, spur_done;
    logic [127:0] eng_res;
    int           start_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt    <= 0;
            eng_done_m <= 1'b0;
            eng_res    <= '0;
            start_cnt  <= 0;
        end else begin
            eng_done_m <= 1'b0;
            if (eng_start) begin
                start_cnt <= start_cnt + 1;
                eng_cnt   <= EngLat;
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) begin
                    eng_done_m <= 1'b1;
                    eng_res    <= engine_fn(eng_a_data, eng_b_data, eng_bias_data);
                end
            end
        end
    end

    // A spurious done carries junk so any wrongful capture corrupts the drained tile.
    assign eng_done         = eng_done_m | spur_done;
    assign eng_result_quant = spur_done ? {16{8'h5A}} : eng_res;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("in_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_tile(input logic [127:0] a, input logic [127:0] b,
                             input logic [127:0] bias, input bit stall, input bit spur,
                             input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            logic [7:0] d;
            if (stall) @(negedge clk);
            if (k < 16)      d = a[k*8 +: 8];
            else if (k < 32) d = b[(k-16)*8 +: 8];
            else             d = bias[(k-32)*8 +: 8];
            spur_done = spur && (k == 22);
            push(d);
            spur_done = 1'b0;
        end
    endtask

    task automatic drain(input logic [127:0] exp, input bit bp, input int spur_beat,
                         input int stop_at);
        int t = 0;
        bit stable;
        logic [7:0] d0;
        logic l0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            check("out_timeout", 0, 1);
            return;
        end
        for (int k = 0; k < 16; k++) begin
            if (k == stop_at) return;
            if (bp && (k == 0 || k == 7 || k == 15)) begin
                out_ready = 1'b0;
                d0 = out_data;
                l0 = out_last;
                stable = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    if (out_data !== d0 || out_last !== l0 || out_valid !== 1'b1) stable = 1'b0;
                end
                check("bp_hold", stable, 1);
            end
            if (k == spur_beat) begin
                out_ready = 1'b0;
                spur_done = 1'b1;
                @(negedge clk);
                spur_done = 1'b0;
            end
            check("valid", out_valid, 1);
            check("beat", out_data, exp[k*8 +: 8]);
            check("last", out_last, k == 15);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [127:0] ta[3], tb[3], tbias[3], texp[3];
    logic [127:0] exp_id, sav_a, sav_b, sav_bias;
    int exp_tab[16] = '{2, 4, 6, 8, 6, 8, 10, 12, 10, 12, 14, 16, 14, 16, 18, 20};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int t = 0; t < 3; t++) begin
            ta[t] = '0;
            tb[t] = '0;
            tbias[t] = '0;
        end
        for (int i = 0; i < 4; i++) ta[0][(i*4+i)*8 +: 8] = 8'd1;
        for (int k = 0; k < 16; k++) tb[0][k*8 +: 8] = 8'(k + 1);
        for (int j = 0; j < 4; j++) tbias[0][j*32 +: 32] = 32'(j + 1);
        for (int t = 1; t < 3; t++) begin
            for (int k = 0; k < 16; k++) begin
                ta[t][k*8 +: 8] = 8'(((k*3 + t) % 7) - 3);
                tb[t][k*8 +: 8] = 8'(((k*5 + 2*t) % 9) - 4);
            end
            for (int j = 0; j < 4; j++) tbias[t][j*32 +: 32] = 32'(t*10 - j*7);
        end
        for (int k = 0; k < 16; k++) exp_id[k*8 +: 8] = 8'(exp_tab[k]);
        texp[0] = exp_id;
        texp[1] = engine_fn(ta[1], tb[1], tbias[1]);
        texp[2] = engine_fn(ta[2], tb[2], tbias[2]);

        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        spur_done = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_tiles", tile_count, 0);
        check("rst_a_bus", eng_a_data, 0);
        check("rst_bias_bus", eng_bias_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity tile, no stalls; junk offered while waiting must be ignored.
        load_tile(ta[0], tb[0], tbias[0], 1'b0, 1'b0, 48);
        check("start_lat", eng_start, 1);
        check("a_bus", eng_a_data, ta[0]);
        check("b_bus", eng_b_data, tb[0]);
        check("bias_bus", eng_bias_data, tbias[0]);
        sav_a = eng_a_data;
        sav_b = eng_b_data;
        sav_bias = eng_bias_data;
        @(negedge clk);
        check("start_pulse", eng_start, 0);
        in_valid = 1'b1;
        in_data = 8'hFF;
        repeat (3) @(negedge clk);
        check("wait_ready", in_ready, 0);
        in_valid = 1'b0;
        check("a_hold", eng_a_data, ta[0]);
        drain(exp_id, 1'b0, -1, 16);
        check("starts_t1", start_cnt, 1);
        check("tiles_t1", tile_count, 1);
        check("idle_t1", busy, 0);

        // Stalled input, then back-pressured output.
        pulse_reset();
        load_tile(ta[0], tb[0], tbias[0], 1'b1, 1'b0, 48);
        check("stall_a", eng_a_data, sav_a);
        check("stall_b", eng_b_data, sav_b);
        check("stall_bias", eng_bias_data, sav_bias);
        drain(exp_id, 1'b1, -1, 16);
        check("tiles_bp", tile_count, 1);

        // Spurious done during LOAD_B and DRAIN.
        load_tile(ta[1], tb[1], tbias[1], 1'b0, 1'b1, 48);
        drain(texp[1], 1'b0, 5, 16);
        check("tiles_spur", tile_count, 2);
        check("starts_spur", start_cnt, 2);

        // Reset after 20 beats, then a clean tile.
        load_tile(ta[2], tb[2], tbias[2], 1'b0, 1'b0, 20);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_tile(ta[1], tb[1], tbias[1], 1'b0, 1'b0, 48);
        drain(texp[1], 1'b0, -1, 16);
        check("tiles_rst", tile_count, 1);
        check("starts_rst", start_cnt, 1);

        // Reset during drain beat 8.
        load_tile(ta[2], tb[2], tbias[2], 1'b0, 1'b0, 48);
        drain(texp[2], 1'b0, -1, 8);
        check("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("drn_rst_valid", out_valid, 0);
        check("drn_rst_ready", in_ready, 1);
        check("drn_rst_busy", busy, 0);
        check("drn_rst_tiles", tile_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Three tiles back to back.
        for (int t = 0; t < 3; t++) begin
            load_tile(ta[t], tb[t], tbias[t], 1'b0, 1'b0, 48);
            drain(texp[t], 1'b0, -1, 16);
        end
        check("tiles_b2b", tile_count, 3);
        check("starts_b2b", start_cnt, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tile_stream_loader.md
# tile_stream_loader

Byte-stream front end for the 4x4 inference pipeline. It accepts A, B and bias tiles over a valid/ready input stream and assembles them into the packed buses the inference engine consumes. It drives the engine's start/done handshake, captures the int8 result tile, and returns it over a valid/ready output stream. It sits between the host/DMA byte interface and the engine, and processes one tile per load–run–drain cycle.

## Interface

Parameters:
- N, 4, tile dimension (N×N elements).
- DATA_WIDTH, 8, element width and stream beat width.
- ACC_WIDTH, 32, bias element width; must be a multiple of DATA_WIDTH.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  loader can accept a beat.
- in_data  in  DATA_WIDTH  input beat.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_WIDTH  result beat.
- out_last  out  1  high on the final beat of a result tile.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_done  in  1  engine completion pulse.
- eng_a_data  out  N*N*DATA_WIDTH  packed A; element (i,j) at [(i*N+j)*DATA_WIDTH +: DATA_WIDTH].
- eng_b_data  out  N*N*DATA_WIDTH  packed B; same packing as A.
- eng_bias_data  out  N*ACC_WIDTH  packed bias; column j at [j*ACC_WIDTH +: ACC_WIDTH].
- eng_result_quant  in  N*N*DATA_WIDTH  engine int8 result; same packing as A.
- busy  out  1  high in every state except LOAD_A.
- tile_count  out  16  completed tiles (drain finished); wraps at 65535→0.

## Operation

- States: LOAD_A, LOAD_B, LOAD_BIAS, START, WAIT, DRAIN.
- in_ready = 1 in LOAD_A, LOAD_B and LOAD_BIAS; 0 otherwise. It is a combinational decode of the state.
- A beat is accepted when in_valid && in_ready. The beat counter idx advances only on an accepted beat.
- LOAD_A:
  - Beat k (k = 0..N*N-1) is written to A element k, row-major.
  - After beat N*N-1 is accepted: idx ← 0, go to LOAD_B.
- LOAD_B: same as LOAD_A, writing into B. After the last beat: idx ← 0, go to LOAD_BIAS.
- LOAD_BIAS:
  - Accepts N*ACC_WIDTH/DATA_WIDTH beats (16 at defaults).
  - Bias word j is little-endian: beat j*4+b fills bits [b*8 +: 8] of word j.
  - After the last beat, go to START.
- START: eng_start = 1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - On eng_done, capture eng_result_quant into the output buffer, idx ← 0, go to DRAIN.
  - eng_done in any other state is ignored.
- DRAIN:
  - out_valid = 1 and out_data = buffer element idx.
  - On out_valid && out_ready, idx advances.
  - out_last = (idx == N*N-1).
  - When the last beat transfers: tile_count increments, go to LOAD_A.
- eng_a_data, eng_b_data and eng_bias_data are registers. They hold their values from the end of loading until they are overwritten by the next tile's load.
- The output buffer is separate from the engine bus. It holds its value through the whole of DRAIN.

## Timing

- Reset values:
  - state = LOAD_A, so in_ready = 1 while in reset and after it.
  - out_valid, out_last, eng_start = 0.
  - out_data = 0.
  - All A/B/bias/result registers = 0.
  - idx = 0, tile_count = 0, busy = 0.
- The input stream accepts at most one beat per cycle, with full throughput and no bubbles across LOAD_A → LOAD_B → LOAD_BIAS.
- Latency:
  - eng_start rises on the cycle after the final bias beat is accepted.
  - The first out_valid is the cycle after eng_done is sampled high in WAIT.
- Back-pressure: while out_valid && !out_ready, out_data and out_last hold stable.
- In DRAIN, out_valid never drops before the last beat transfers.
- A tile with no stalls takes 48 load cycles, then 1 START cycle, then the engine latency, then 1 capture cycle, then 16 drain cycles.
- A new tile's first A beat can be accepted on the cycle after the final output beat transfers.
- in_valid while in_ready = 0: the beat is not consumed and has no effect.
- Asynchronous reset mid-operation:
  - All state clears immediately.
  - Any partial tile is discarded, with no eng_start and no output.
  - After reset, loading restarts at A element 0.

## Test plan

- Full tile through a real engine (bias on, relu and requant off):
  - Stimulus: A = identity, B = 1..16 row-major, bias = [1,2,3,4].
  - Required: exactly one eng_start pulse; output row0 = 2,4,6,8 and row3 = 14,16,18,20; out_last only on the 16th beat; tile_count = 1.
- Input stalls: in_valid toggling every other cycle across all 48 beats → packed eng_a_data, eng_b_data and eng_bias_data are identical to the no-stall run.
- Output back-pressure: out_ready low for 5 cycles on beats 0, 7 and 15 → out_data and out_last hold stable during each stall; the beat order is unchanged.
- Spurious eng_done pulsed during LOAD_B and DRAIN → no state change and no capture; the result matches the reference values.
- Reset mid-operation:
  - rst_n asserted after 20 A/B beats, then a full clean tile → only the clean tile's result is emitted; tile_count = 1.
  - rst_n asserted during DRAIN beat 8 → out_valid drops at once and state = LOAD_A.
- Back-to-back tiles: three tiles streamed continuously with an engine model of fixed 10-cycle latency → three correct result tiles, in order; tile_count = 3.
